// File: rtl/ripple_ide_pkg.sv
// Shared types and default timing for the RIPPLE IDE PIO sequencer.
package ripple_ide_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StAck,
        StRecover
    } ide_state_e;

    localparam int unsigned DefSetupCyc    = 1;
    localparam int unsigned DefStrobeFast  = 2;
    localparam int unsigned DefStrobeSlow  = 4;
    localparam int unsigned DefRecoveryCyc = 2;
    localparam int unsigned DefTimeoutCyc  = 200;

    localparam int unsigned PhaseW = 4;
    localparam int unsigned WaitW  = 8;

    typedef logic [PhaseW-1:0] phase_t;
    typedef logic [WaitW-1:0]  wait_t;

    // Terminal phase count for a phase lasting 'cycles' clocks; 0 behaves as 1.
    function automatic phase_t last_phase(input int unsigned cycles);
        return (cycles == 0) ? phase_t'(0) : phase_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/ide_iordy_sync.sv
// Two-flop synchronizer for the drive's IORDY; resets to ready so an
// undriven (pulled-up) IORDY never stalls an access.
module ide_iordy_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift IORDY through two flops to settle metastability.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/ide_pio_sequencer.sv
// Turns one 68000 bus cycle into timed IDE chip-select, IOR_n/IOW_n and DTACK.
module ide_pio_sequencer
    import ripple_ide_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = DefSetupCyc,
    parameter int unsigned STROBE_FAST  = DefStrobeFast,
    parameter int unsigned STROBE_SLOW  = DefStrobeSlow,
    parameter int unsigned RECOVERY_CYC = DefRecoveryCyc,
    parameter int unsigned TIMEOUT_CYC  = DefTimeoutCyc
) (
    input  logic CLK,
    input  logic RESET,
    input  logic AS_n,
    input  logic UDS_n,
    input  logic LDS_n,
    input  logic RW,
    input  logic ide_access,
    input  logic ide_enable,
    input  logic cs_sel,
    input  logic FAST,
    input  logic IORDY,
    output logic IDECS1_n,
    output logic IDECS2_n,
    output logic IOR_n,
    output logic IOW_n,
    output logic DTACK,
    output logic busy,
    output logic timeout
);

    localparam phase_t SetupLast    = last_phase(SETUP_CYC);
    localparam phase_t FastLast     = last_phase(STROBE_FAST);
    localparam phase_t SlowLast     = last_phase(STROBE_SLOW);
    localparam phase_t RecoveryLast = last_phase(RECOVERY_CYC);
    localparam wait_t  TimeoutVal   = wait_t'(TIMEOUT_CYC);

    ide_state_e state_q, state_d;
    phase_t     phase_q, phase_d;
    wait_t      wait_q, wait_d;
    logic       rw_q, rw_d, sel_q, sel_d, fast_q, fast_d, timeout_q, timeout_d;
    logic       cs1_n_q, cs1_n_d, cs2_n_q, cs2_n_d, ior_n_q, ior_n_d, iow_n_q, iow_n_d;
    logic       dtack_q, dtack_d, busy_q, busy_d;
    logic       iordy_s, start, cs_active;
    phase_t     strobe_last;

    ide_iordy_sync u_iordy_sync (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (IORDY),
        .q_o   (iordy_s)
    );

    assign start       = !AS_n && ide_access && ide_enable && (!UDS_n || !LDS_n);
    assign strobe_last = fast_q ? FastLast : SlowLast;

    // Next-state sequencing, plus output levels decoded from the next state so
    // every pin comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        wait_d    = wait_q;
        rw_d      = rw_q;
        sel_d     = sel_q;
        fast_d    = fast_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    phase_d = '0;
                    wait_d  = '0;
                    rw_d    = RW;
                    sel_d   = cs_sel;
                    fast_d  = FAST;
                end
            end
            StSetup: begin
                if (AS_n) begin
                    state_d = StRecover;
                    phase_d = '0;
                end else if (phase_q == SetupLast) begin
                    state_d = StStrobe;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + phase_t'(1);
                end
            end
            StStrobe: begin
                if (AS_n) begin
                    state_d = StRecover;
                    phase_d = '0;
                end else if (phase_q != strobe_last) begin
                    phase_d = phase_q + phase_t'(1);
                end else if (iordy_s) begin
                    state_d = StAck;
                end else begin
                    // Drive not ready: stretch the strobe, bounded by the timeout.
                    wait_d = wait_q + wait_t'(1);
                    if (wait_d == TimeoutVal) begin
                        timeout_d = 1'b1;
                        state_d   = StAck;
                    end
                end
            end
            StAck: begin
                if (AS_n) begin
                    state_d = StRecover;
                    phase_d = '0;
                end
            end
            StRecover: begin
                if (phase_q == RecoveryLast) begin
                    state_d = StIdle;
                end else begin
                    phase_d = phase_q + phase_t'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        cs_active = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StAck);
        cs1_n_d   = !(cs_active && !sel_d);
        cs2_n_d   = !(cs_active && sel_d);
        // Reads keep IOR_n low through ACK; writes release IOW_n on ACK entry.
        ior_n_d   = !(((state_d == StStrobe) || (state_d == StAck)) && rw_d);
        iow_n_d   = !((state_d == StStrobe) && !rw_d);
        dtack_d   = (state_d == StAck);
        busy_d    = (state_d != StIdle);
    end

    // State, latched access attributes and registered pin levels.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            wait_q    <= '0;
            rw_q      <= 1'b0;
            sel_q     <= 1'b0;
            fast_q    <= 1'b0;
            timeout_q <= 1'b0;
            cs1_n_q   <= 1'b1;
            cs2_n_q   <= 1'b1;
            ior_n_q   <= 1'b1;
            iow_n_q   <= 1'b1;
            dtack_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            wait_q    <= wait_d;
            rw_q      <= rw_d;
            sel_q     <= sel_d;
            fast_q    <= fast_d;
            timeout_q <= timeout_d;
            cs1_n_q   <= cs1_n_d;
            cs2_n_q   <= cs2_n_d;
            ior_n_q   <= ior_n_d;
            iow_n_q   <= iow_n_d;
            dtack_q   <= dtack_d;
            busy_q    <= busy_d;
        end
    end

    assign IDECS1_n = cs1_n_q;
    assign IDECS2_n = cs2_n_q;
    assign IOR_n    = ior_n_q;
    assign IOW_n    = iow_n_q;
    assign DTACK    = dtack_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Scoreboard bench for ide_pio_sequencer: the driver predicts each access's
// observable shape, a monitor measures it from the pins and compares.
module tb_ide_pio_sequencer;

    localparam int SETUP = 1;
    localparam int SFAST = 2;
    localparam int SSLOW = 4;
    localparam int REC   = 2;
    localparam int TMO   = 200;

    logic CLK = 1'b0;
    logic RESET, AS_n, UDS_n, LDS_n, RW, ide_access, ide_enable, cs_sel, FAST, IORDY;
    logic IDECS1_n, IDECS2_n, IOR_n, IOW_n, DTACK, busy, timeout;

    always #5 CLK = ~CLK;

    ide_pio_sequencer #(
        .SETUP_CYC    (SETUP),
        .STROBE_FAST  (SFAST),
        .STROBE_SLOW  (SSLOW),
        .RECOVERY_CYC (REC),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .AS_n       (AS_n),
        .UDS_n      (UDS_n),
        .LDS_n      (LDS_n),
        .RW         (RW),
        .ide_access (ide_access),
        .ide_enable (ide_enable),
        .cs_sel     (cs_sel),
        .FAST       (FAST),
        .IORDY      (IORDY),
        .IDECS1_n   (IDECS1_n),
        .IDECS2_n   (IDECS2_n),
        .IOR_n      (IOR_n),
        .IOW_n      (IOW_n),
        .DTACK      (DTACK),
        .busy       (busy),
        .timeout    (timeout)
    );

    typedef struct {
        bit sel;
        bit rw;
        bit ack;
        int setup;
        int strobe;
        bit tmo;
        int rec;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   to_model = 1'b0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_cs1_n"}, IDECS1_n, 1);
        check({pfx, "_cs2_n"}, IDECS2_n, 1);
        check({pfx, "_ior_n"}, IOR_n, 1);
        check({pfx, "_iow_n"}, IOW_n, 1);
        check({pfx, "_dtack"}, DTACK, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_timeout"}, timeout, 0);
    endtask

    // mode 0: normal, 1: AS_n drops in first strobe cycle, 2: RESET mid-strobe.
    // h > 0 holds IORDY low for the first h clock edges of the access.
    // b2b returns without waiting for idle so the next access lands in RECOVER.
    task automatic do_access(input bit rw, input bit sel, input bit fast, input int h,
                             input int mode, input bit b2b);
        exp_t e;
        int   s, n, ack_e, c;
        bit   done, drop;
        s = SETUP + 1;                     // edge on which the strobe falls
        n = fast ? SFAST : SSLOW;
        e.sel = sel;
        e.rw = rw;
        e.setup = SETUP;
        e.tmo = 1'b0;
        if (mode == 0) begin
            // Ready seen two sync edges after IORDY is sampled high, checked from s+n on,
            // and forced after TMO failed checks.
            ack_e = s + n;
            if (h > 0 && h + 3 > ack_e) ack_e = h + 3;
            if (ack_e > s + n + TMO - 1) begin
                ack_e = s + n + TMO - 1;
                to_model = 1'b1;
            end
            e.ack = 1'b1;
            e.strobe = ack_e - s;
            e.tmo = to_model;
            e.rec = REC;
        end else if (mode == 1) begin
            e.ack = 1'b0;
            e.strobe = 1;
            e.rec = REC;
        end else begin
            e.ack = 1'b0;
            e.strobe = 2;
            e.rec = 0;
        end
        exp_q.push_back(e);
        drop = ($urandom_range(0, 3) == 0);

        @(negedge CLK);
        AS_n = 1'b0;
        c = $urandom_range(0, 2);
        UDS_n = (c == 1);
        LDS_n = (c == 2);
        RW = rw;
        cs_sel = sel;
        FAST = fast;
        ide_access = 1'b1;
        ide_enable = 1'b1;
        IORDY = (h > 0) ? 1'b0 : 1'b1;

        c = 0;
        done = 1'b0;
        while (!done && c < 400) begin
            @(negedge CLK);
            c++;
            if (h > 0 && c == h) IORDY = 1'b1;
            if (drop && c == 1) ide_enable = 1'b0;
            if (mode == 1 && c == 2) done = 1'b1;
            if (mode == 2 && c == 3) done = 1'b1;
            if (mode == 0 && DTACK) done = 1'b1;
        end
        if (mode == 0) check("dtack_seen", done, 1);

        if (mode == 2) begin
            RESET = 1'b1;
            #1;
            check_idle("async_reset");
            AS_n = 1'b1;
            UDS_n = 1'b1;
            LDS_n = 1'b1;
            ide_access = 1'b0;
            ide_enable = 1'b1;
            IORDY = 1'b1;
            @(negedge CLK);
            RESET = 1'b0;
            to_model = 1'b0;
            return;
        end

        if (mode == 0) repeat ($urandom_range(0, 2)) @(negedge CLK);
        AS_n = 1'b1;
        UDS_n = 1'b1;
        LDS_n = 1'b1;
        ide_access = 1'b0;
        ide_enable = 1'b1;
        IORDY = 1'b1;
        if (!b2b) begin
            c = 0;
            while (busy && c < 50) begin
                @(negedge CLK);
                c++;
            end
            check("idle_return", busy, 0);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
    endtask

    // Monitor: measures each chip-select episode from the pins and scores it.
    initial begin : monitor
        exp_t e;
        bit   sel, saw_r, saw_w, ack, to_s, hold_ok, ack_ior, ack_iow, pending;
        int   setup, strobe, rec;
        pending = 1'b0;
        forever begin
            if (!pending) begin
                @(posedge CLK);
                #1;
            end
            pending = 1'b0;
            if (!(IDECS1_n && IDECS2_n)) begin
                sel = !IDECS2_n;
                saw_r = 0; saw_w = 0; ack = 0; to_s = 0; hold_ok = 1;
                ack_ior = 1; ack_iow = 1; setup = 0; strobe = 0;
                while (!IDECS1_n || !IDECS2_n) begin
                    if (DTACK) begin
                        if (!ack) begin
                            ack = 1;
                            to_s = timeout;
                            ack_ior = IOR_n;
                            ack_iow = IOW_n;
                        end else if (saw_r && IOR_n) begin
                            hold_ok = 0;
                        end
                    end else if (!IOR_n || !IOW_n) begin
                        strobe++;
                        if (!IOR_n) saw_r = 1;
                        if (!IOW_n) saw_w = 1;
                    end else begin
                        setup++;
                    end
                    @(posedge CLK);
                    #1;
                end
                rec = 0;
                while (busy && IDECS1_n && IDECS2_n) begin
                    rec++;
                    @(posedge CLK);
                    #1;
                end
                pending = 1'b1;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_access: got access sel=%0d, expected none", sel);
                end else begin
                    e = exp_q.pop_front();
                    check("cs_sel", sel, e.sel);
                    check("ack", ack, e.ack);
                    check("setup_cycles", setup, e.setup);
                    check("strobe_cycles", strobe, e.strobe);
                    check("strobe_dir", saw_r ? 1 : (saw_w ? 0 : 2), e.rw);
                    check("single_strobe", saw_r && saw_w, 0);
                    check("recover_cycles", rec, e.rec);
                    if (e.ack) begin
                        check("timeout_at_ack", to_s, e.tmo);
                        check("ack_ior_n", ack_ior, e.rw ? 0 : 1);
                        check("ack_iow_n", ack_iow, 1);
                        if (e.rw) check("read_hold", hold_ok, 1);
                    end
                end
            end
        end
    end

    // Pin-level invariant: one strobe at most, and only under a chip select.
    initial begin : invariant
        forever begin
            @(posedge CLK);
            #1;
            check("strobe_needs_cs",
                  int'((!IOR_n && !IOW_n) || ((!IOR_n || !IOW_n) && IDECS1_n && IDECS2_n)), 0);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit rw, sel, fast;
        int h, mode;
        RESET = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
        ide_access = 1'b0; ide_enable = 1'b1; cs_sel = 1'b0; FAST = 1'b1; IORDY = 1'b1;
        repeat (3) @(negedge CLK);
        check_idle("in_reset");
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check_idle("after_reset");

        do_access(1, 0, 1, 0, 0, 0);    // read, FAST
        do_access(0, 1, 0, 0, 0, 0);    // write to CS2, slow strobe
        do_access(1, 0, 1, 10, 0, 0);   // IORDY low for 10 edges
        do_access(1, 1, 0, 0, 1, 0);    // abort in first strobe cycle

        // Valid hit while disabled must not start anything.
        @(negedge CLK);
        AS_n = 1'b0; UDS_n = 1'b0; ide_access = 1'b1; ide_enable = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            check("disabled_busy", busy, 0);
            check("disabled_cs1_n", IDECS1_n, 1);
        end
        AS_n = 1'b1; UDS_n = 1'b1; ide_access = 1'b0; ide_enable = 1'b1;
        repeat (2) @(negedge CLK);

        do_access(0, 0, 1, 0, 0, 1);    // followed at once by another access
        do_access(1, 1, 1, 0, 0, 0);

        repeat (20) begin
            rw = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            fast = 1'($urandom_range(0, 1));
            mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
            h = ($urandom_range(0, 1) == 0 || mode != 0) ? 0 : $urandom_range(1, 20);
            do_access(rw, sel, fast, h, mode, 0);
        end

        do_access(1, 0, 1, 250, 0, 0);  // IORDY stuck low past the timeout
        do_access(0, 0, 0, 0, 0, 0);    // flag stays set
        do_access(1, 1, 1, 3, 0, 0);
        do_access(1, 0, 0, 0, 2, 0);    // RESET during strobe clears everything
        do_access(0, 1, 1, 0, 0, 0);
        do_access(1, 0, 0, 5, 0, 0);

        repeat (5) @(negedge CLK);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
